// File: rtl/io_pkg.sv
// -----------------------------------------------------------------------------
// io_pkg
// Shared definitions for the processor I/O port responder.
//   IO_DATA_WIDTH : default accumulator / I/O word width
//   IO_OUT_DEPTH  : default number of OUT FIFO entries (power of two, >= 2)
//   in_state_e    : IN holding register state (IN_EMPTY=0, IN_FULL=1)
// The optional loopback path in io_port_responder is controlled by the macro
// IO_PORT_LOOPBACK_EN; this package does not depend on it.
// -----------------------------------------------------------------------------
package io_pkg;

   localparam int IO_DATA_WIDTH = 16;
   localparam int IO_OUT_DEPTH  = 4;

   typedef enum logic {
      IN_EMPTY = 1'b0,
      IN_FULL  = 1'b1
   } in_state_e;

   // Pointer width for a FIFO of the given depth; never returns 0 so that a
   // pointer vector is always at least one bit wide.
   function automatic int ptr_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage : io_pkg

// File: rtl/io_out_fifo.sv
// -----------------------------------------------------------------------------
// io_out_fifo
// Small synchronous FIFO buffering words written by the `out` instruction
// until the external device takes them.
//
// Parameters:
//   DATA_WIDTH : word width
//   DEPTH      : number of entries, power of two, at least 2
//
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   push         : write request; accepted when not full, or when a pop
//                  happens in the same cycle
//   push_data    : word written on an accepted push
//   pop          : read request; ignored while empty
//   head_data    : combinational read of the oldest entry (don't-care if empty)
//   empty        : no entries held
//   full         : DEPTH entries held
//   overflow     : sticky, a push was refused because the FIFO was full
// -----------------------------------------------------------------------------
module io_out_fifo
   import io_pkg::*;
#(
   parameter int DATA_WIDTH = IO_DATA_WIDTH,
   parameter int DEPTH      = IO_OUT_DEPTH
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] push_data,
   input  logic                  pop,
   output logic [DATA_WIDTH-1:0] head_data,
   output logic                  empty,
   output logic                  full,
   output logic                  overflow
);

   localparam int PTR_W = ptr_width(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]      count_q, count_d;
   logic                  overflow_q, overflow_d;
   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] mem_d [DEPTH];

   logic do_push;
   logic do_pop;

   assign empty     = (count_q == '0);
   assign full      = (count_q == CNT_W'(DEPTH));
   assign overflow  = overflow_q;
   assign head_data = mem_q[rd_ptr_q];

   // A pop frees a slot in the same cycle, so a full FIFO can still take a
   // push alongside a pop.
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q;

      // DEPTH is a power of two, so natural pointer overflow is the wrap.
      if (do_push) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end

      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase

      if (push && !do_push) begin
         overflow_d = 1'b1;
      end
   end

   always_comb begin
      mem_d = mem_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

   // Storage holds no state that matters after reset, so it is not reset.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule : io_out_fifo

// File: rtl/io_port_responder.sv
// -----------------------------------------------------------------------------
// io_port_responder
// Peripheral-side responder for the processor's `in` / `out` instructions.
//   OUT path: OutWrite strobes push the accumulator value into io_out_fifo,
//             which drains to the device over dev_out_valid/dev_out_ready.
//   IN path : a one-word holding register (two-state FSM) captures a device
//             word over dev_in_valid/dev_in_ready; InRead consumes it.
//
// Handshake semantics (both device interfaces): a word transfers on a rising
// clk edge where valid and ready are both 1. The sender holds data and valid
// stable until the transfer; ready may change freely in any cycle.
//
// Parameters:
//   DATA_WIDTH : accumulator / I/O word width
//   OUT_DEPTH  : OUT FIFO entries (power of two, >= 2)
//
// Ports:
//   clk, reset                  : clock, synchronous active-high reset
//   OutWrite, OutData           : `out` strobe and accumulator value
//   InRead                      : `in` strobe (ACC loads InData this cycle)
//   InData                      : holding register, to ACC mux input 01
//   dev_out_data/valid/ready    : OUT device handshake (FIFO head)
//   dev_in_data/valid/ready     : IN device handshake
//   out_full                    : OUT FIFO holds OUT_DEPTH words
//   in_avail                    : holding register has an unread word
//   out_overflow                : sticky, an OutWrite was dropped
//   loopback (only with IO_PORT_LOOPBACK_EN)
//                               : route FIFO head into the holding register
//                                 instead of the device interfaces
// -----------------------------------------------------------------------------
module io_port_responder
   import io_pkg::*;
#(
   parameter int DATA_WIDTH = IO_DATA_WIDTH,
   parameter int OUT_DEPTH  = IO_OUT_DEPTH
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  OutWrite,
   input  logic [DATA_WIDTH-1:0] OutData,
   input  logic                  InRead,
   output logic [DATA_WIDTH-1:0] InData,
   output logic [DATA_WIDTH-1:0] dev_out_data,
   output logic                  dev_out_valid,
   input  logic                  dev_out_ready,
   input  logic [DATA_WIDTH-1:0] dev_in_data,
   input  logic                  dev_in_valid,
   output logic                  dev_in_ready,
   output logic                  out_full,
   output logic                  in_avail,
`ifdef IO_PORT_LOOPBACK_EN
   input  logic                  loopback,
`endif
   output logic                  out_overflow
);

   // ---------------------------------------------------------------------------
   // OUT FIFO
   // ---------------------------------------------------------------------------
   logic                  fifo_pop;
   logic [DATA_WIDTH-1:0] fifo_head;
   logic                  fifo_empty;
   logic                  fifo_full;
   logic                  fifo_overflow;

   io_out_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (OUT_DEPTH)
   ) u_out_fifo (
      .clk        (clk),
      .reset      (reset),
      .push       (OutWrite),
      .push_data  (OutData),
      .pop        (fifo_pop),
      .head_data  (fifo_head),
      .empty      (fifo_empty),
      .full       (fifo_full),
      .overflow   (fifo_overflow)
   );

   assign dev_out_data = fifo_head;
   assign out_full     = fifo_full;
   assign out_overflow = fifo_overflow;

   // ---------------------------------------------------------------------------
   // IN holding register state; in_state_q is the FSM state, in_avail is its
   // direct decode.
   // ---------------------------------------------------------------------------
   in_state_e             in_state_q, in_state_d;
   logic [DATA_WIDTH-1:0] in_data_q, in_data_d;

   logic                  cap_valid;  // holding register loads this cycle
   logic [DATA_WIDTH-1:0] cap_data;

`ifdef IO_PORT_LOOPBACK_EN
   // In loopback both device interfaces are closed and the FIFO head is moved
   // straight into the holding register whenever it is free. Both handshakes
   // are gated by loopback in the same cycle, so a switch at an edge can
   // neither drop nor repeat a word.
   logic lb_capture;

   assign dev_out_valid = !fifo_empty && !loopback;
   assign dev_in_ready  = (in_state_q == IN_EMPTY) && !loopback;
   assign lb_capture    = loopback && (in_state_q == IN_EMPTY) && !fifo_empty;
   assign fifo_pop      = (dev_out_valid && dev_out_ready) || lb_capture;
   assign cap_valid     = lb_capture || (dev_in_ready && dev_in_valid);
   assign cap_data      = loopback ? fifo_head : dev_in_data;
`else
   assign dev_out_valid = !fifo_empty;
   assign dev_in_ready  = (in_state_q == IN_EMPTY);
   assign fifo_pop      = dev_out_valid && dev_out_ready;
   assign cap_valid     = dev_in_ready && dev_in_valid;
   assign cap_data      = dev_in_data;
`endif

   // InRead while EMPTY just returns the stale InData. When InRead and a
   // capture coincide in EMPTY, the capture wins: the ACC sees the old value
   // this cycle and the new word is held for a later `in`.
   always_comb begin
      in_state_d = in_state_q;
      in_data_d  = in_data_q;
      case (in_state_q)
         IN_EMPTY: begin
            if (cap_valid) begin
               in_state_d = IN_FULL;
               in_data_d  = cap_data;
            end
         end
         IN_FULL: begin
            // Consuming the word frees the register but keeps its value.
            if (InRead) begin
               in_state_d = IN_EMPTY;
            end
         end
         default: begin
            in_state_d = IN_EMPTY;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         in_state_q <= IN_EMPTY;
         in_data_q  <= '0;
      end else begin
         in_state_q <= in_state_d;
         in_data_q  <= in_data_d;
      end
   end

   assign InData   = in_data_q;
   assign in_avail = (in_state_q == IN_FULL);

endmodule : io_port_responder
